// File: rtl/mult_pkg.sv
// Shared encodings for the iterative multiplier: FSM state codes and default operand width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: WIDTH+2 edges from accepted start to the done pulse, busy for WIDTH+1 cycles.
// No queuing: start is ignored while busy, and abort flushes to IDLE without a done pulse.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic               neg;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept = start && !abort && (state == IDLE || state == DONE);

  // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is correct when read as unsigned.
  assign a_mag = (signed_op && op_a[WIDTH-1]) ? (WIDTH'(0) - op_a) : op_a;
  assign b_mag = (signed_op && op_b[WIDTH-1]) ? (WIDTH'(0) - op_b) : op_b;

  // Carry out of the upper-half add lands in the top bit after the shift.
  assign sum      = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign prod_raw = {acc_hi, mplier};
  assign prod_fix = neg ? ((2*WIDTH)'(0) - prod_raw) : prod_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (accept) begin
      state  <= RUN;
      mcand  <= a_mag;
      mplier <= b_mag;
      acc_hi <= '0;
      neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc_hi <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          prod_hi <= prod_fix[2*WIDTH-1:WIDTH];
          prod_lo <= prod_fix[WIDTH-1:0];
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized bench for seq_multiplier: cycle-count reference model plus literal corner checks.
module tb_seq_multiplier;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          signed_op = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          busy, done;
  logic [W-1:0]  prod_hi, prod_lo;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1..W+1 busy, W+2 done; product appears on entry to done.
  int             m_cnt  = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (abort) begin
      m_cnt <= 0;
    end else if ((m_cnt == 0 || m_cnt == W+2) && start) begin
      m_cnt  <= 1;
      m_pend <= ref_prod(op_a, op_b, signed_op);
    end else if (m_cnt >= 1 && m_cnt <= W) begin
      m_cnt <= m_cnt + 1;
    end else if (m_cnt == W+1) begin
      m_cnt  <= W+2;
      m_prod <= m_pend;
    end else begin
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {63'd0, busy}, {63'd0, (m_cnt >= 1 && m_cnt <= W+1)});
      check("cyc_done", {63'd0, done}, {63'd0, (m_cnt == W+2)});
      check("cyc_prod", {prod_hi, prod_lo}, m_prod);
    end
  end

  int             lat;
  logic           snap_busy;
  logic [2*W-1:0] snap_prod;

  // Called at a negedge: pulse start, then wait (bounded) for done.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start = 1'b1; op_a = a; op_b = b; signed_op = s;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    lat = 1;
    snap_busy = busy;
    snap_prod = {prod_hi, prod_lo};
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start_and_wait(a, b, s);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone, gaps;
    logic [2*W-1:0] keep;
    logic [W-1:0] ra, rb;
    logic rs;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, prod_hi}, 64'd0);
    check("rst_lo", {32'd0, prod_lo}, 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(32'd7, 32'd6, 1'b0);
    check("u7x6_lat", 64'(lat), 64'd34);
    check("u7x6_hi", {32'd0, prod_hi}, 64'd0);
    check("u7x6_lo", {32'd0, prod_lo}, 64'h2A);

    run_op(-32'sd3, 32'd5, 1'b1);
    check("sm3x5", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("umax_sq", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("smin_xm1", {prod_hi, prod_lo}, 64'h0000_0000_8000_0000);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("smin_sq", {prod_hi, prod_lo}, 64'h4000_0000_0000_0000);

    // Start pulses mid-run are ignored; operands changing after accept do not matter.
    @(negedge clk);
    start = 1'b1; op_a = 32'd1000; op_b = 32'd1000; signed_op = 1'b0;
    ndone = 0; gaps = 0; keep = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 10);
      op_a = $urandom; op_b = $urandom; signed_op = $urandom_range(0, 1);
      if (c <= 33 && !busy) gaps++;
      if (done) begin
        ndone++;
        keep = {prod_hi, prod_lo};
      end
    end
    start = 1'b0;
    check("ign_gaps", 64'(gaps), 64'd0);
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_prod", keep, 64'd1000000);

    // Back-to-back: start in the DONE cycle.
    run_op(32'd12, 32'd12, 1'b0);
    start_and_wait(-32'sd2, 32'd9, 1'b1);
    check("b2b_busy", {63'd0, snap_busy}, 64'd1);
    check("b2b_hold", snap_prod, 64'd144);
    check("b2b_lat", 64'(lat), 64'd34);
    check("b2b_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFEE);

    // Asynchronous reset mid-run.
    @(negedge clk);
    start = 1'b1; op_a = 32'd55; op_b = 32'd77; signed_op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_prod", {prod_hi, prod_lo}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Abort mid-run keeps the previous product and suppresses done.
    run_op(32'd7, 32'd9, 1'b0);
    @(negedge clk);
    start = 1'b1; op_a = 32'h1234; op_b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", 64'(ndone), 64'd0);
    check("abort_prod", {prod_hi, prod_lo}, 64'd63);

    // Abort and start together: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      ra = pick(); rb = pick(); rs = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) start_and_wait(ra, rb, rs);
      else run_op(ra, rb, rs);
      check("rnd_lat", 64'(lat), 64'd34);
      check("rnd_prod", {prod_hi, prod_lo}, ref_prod(ra, rb, rs));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
